// File: rtl/qmax_pkg.sv
// qmax_pkg: shared defaults, FSM state and entry types for the Q-max update table.
package qmax_pkg;
    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 6;
    localparam int DEPTH      = 64;
    localparam int ACT_WIDTH  = 2;
    localparam int INIT_VAL   = 0;

    typedef enum logic [0:0] {SWEEP = 1'b0, RUN = 1'b1} state_e;

    typedef struct packed {
        logic signed [DATA_WIDTH-1:0] q;
        logic [ACT_WIDTH-1:0]         act;
    } entry_t;
endpackage

// File: rtl/qmax_sdp_ram.sv
// qmax_sdp_ram: 1R1W RAM, registered read-first output, array left unreset for BRAM inference.
module qmax_sdp_ram #(
    parameter int WIDTH      = 10,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 64
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [WIDTH-1:0]      rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/qmax_update_table.sv
// qmax_update_table: per-state running max Q and argmax action, 2-stage compare-and-store
// with forwarding, plus a sweep-clear engine.
module qmax_update_table #(
    parameter int DATA_WIDTH = qmax_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = qmax_pkg::ADDR_WIDTH,
    parameter int DEPTH      = qmax_pkg::DEPTH,
    parameter int ACT_WIDTH  = qmax_pkg::ACT_WIDTH,
    parameter int INIT_VAL   = qmax_pkg::INIT_VAL
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clear,
    output logic                  o_ready,
    input  logic                  i_upd_valid,
    input  logic [ADDR_WIDTH-1:0] i_upd_addr,
    input  logic [DATA_WIDTH-1:0] i_upd_data,
    input  logic [ACT_WIDTH-1:0]  i_upd_act,
    output logic                  o_upd_improved,
    input  logic                  i_read_en,
    input  logic [ADDR_WIDTH-1:0] i_addr_r,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [ACT_WIDTH-1:0]  o_act,
    output logic                  o_rd_valid
);
    import qmax_pkg::*;

    localparam int EW = DATA_WIDTH + ACT_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [EW-1:0] INIT_ENTRY = {DATA_WIDTH'(INIT_VAL), {ACT_WIDTH{1'b0}}};

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] sweep_addr_q, sweep_addr_d;
    logic                  s1_valid_q, s1_valid_d;
    logic [ADDR_WIDTH-1:0] s1_addr_q;
    logic [EW-1:0]         s1_cand_q;
    logic                  fwd_valid_q;
    logic [ADDR_WIDTH-1:0] fwd_addr_q;
    logic [EW-1:0]         fwd_entry_q;
    logic                  rd_valid_q, rd_hit_q, rd_byp_q, imp_q;
    logic [EW-1:0]         ram_a_q, ram_b_q, stored, rd_entry, wdata;
    logic [ADDR_WIDTH-1:0] waddr;
    logic                  sweep, sweep_done, acc_clr, acc_upd, acc_rd, upd_we, we;

    assign o_ready = state_q == RUN;

    always_comb begin
        sweep      = state_q == SWEEP;
        sweep_done = sweep && sweep_addr_q == LAST;
        acc_clr    = i_clear && o_ready;
        acc_upd    = i_upd_valid && o_ready && !i_clear;
        acc_rd     = i_read_en && o_ready;
        s1_valid_d = acc_upd && {1'b0, i_upd_addr} < DEPTH_W;
        // The previous edge's write is not yet visible in the read-first RAM word.
        stored = (fwd_valid_q && fwd_addr_q == s1_addr_q) ? fwd_entry_q : ram_a_q;
        // {cand, 0} > {q, act} holds exactly when cand > q, so ties never replace.
        upd_we = s1_valid_q &&
                 ($signed({s1_cand_q[EW-1:ACT_WIDTH], {ACT_WIDTH{1'b0}}}) > $signed(stored));
        we     = !i_rst && (sweep || upd_we);
        waddr  = sweep ? sweep_addr_q : s1_addr_q;
        wdata  = sweep ? INIT_ENTRY : s1_cand_q;
        state_d      = acc_clr ? SWEEP : sweep_done ? RUN : state_q;
        sweep_addr_d = (acc_clr || sweep_done) ? '0 : sweep ? sweep_addr_q + 1'b1 : sweep_addr_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= SWEEP;
            sweep_addr_q <= '0;
            s1_valid_q   <= 1'b0;
            fwd_valid_q  <= 1'b0;
            rd_valid_q   <= 1'b0;
            imp_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sweep_addr_q <= sweep_addr_d;
            s1_valid_q   <= s1_valid_d;
            fwd_valid_q  <= we;
            rd_valid_q   <= acc_rd;
            imp_q        <= upd_we;
        end
    end

    always_ff @(posedge i_clk) begin
        s1_addr_q   <= i_upd_addr;
        s1_cand_q   <= {i_upd_data, i_upd_act};
        fwd_addr_q  <= waddr;
        fwd_entry_q <= wdata;
        rd_hit_q    <= {1'b0, i_addr_r} < DEPTH_W;
        rd_byp_q    <= we && waddr == i_addr_r;
    end

    qmax_sdp_ram #(.WIDTH(EW), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_ram_upd (
        .clk_i   (i_clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (i_upd_addr),
        .rdata_o (ram_a_q)
    );

    qmax_sdp_ram #(.WIDTH(EW), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_ram_rd (
        .clk_i   (i_clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (i_addr_r),
        .rdata_o (ram_b_q)
    );

    assign rd_entry       = rd_byp_q ? fwd_entry_q : ram_b_q;
    assign o_data         = (rd_valid_q && rd_hit_q) ? rd_entry[EW-1:ACT_WIDTH] : '0;
    assign o_act          = (rd_valid_q && rd_hit_q) ? rd_entry[ACT_WIDTH-1:0] : '0;
    assign o_rd_valid     = rd_valid_q;
    assign o_upd_improved = imp_q;
endmodule

// File: tb/tb_qmax_update_table.sv
// tb_qmax_update_table: scoreboard bench driving a default instance and an INIT_VAL=-128
// instance with identical stimulus.
module tb_qmax_update_table;
    logic       clk = 1'b0, rst = 1'b1, clr = 1'b0, upd_v = 1'b0, rd_en = 1'b0;
    logic [5:0] upd_addr = '0, rd_addr = '0;
    logic [7:0] upd_data = '0;
    logic [1:0] upd_act = '0;
    logic       ready0, readyn, imp0, impn, rv0, rvn;
    logic [7:0] d0, dn;
    logic [1:0] a0, an;

    always #5 clk = ~clk;

    qmax_update_table dut0 (
        .i_clk(clk), .i_rst(rst), .i_clear(clr), .o_ready(ready0),
        .i_upd_valid(upd_v), .i_upd_addr(upd_addr), .i_upd_data(upd_data), .i_upd_act(upd_act),
        .o_upd_improved(imp0), .i_read_en(rd_en), .i_addr_r(rd_addr),
        .o_data(d0), .o_act(a0), .o_rd_valid(rv0)
    );

    qmax_update_table #(.INIT_VAL(-128)) dutn (
        .i_clk(clk), .i_rst(rst), .i_clear(clr), .o_ready(readyn),
        .i_upd_valid(upd_v), .i_upd_addr(upd_addr), .i_upd_data(upd_data), .i_upd_act(upd_act),
        .o_upd_improved(impn), .i_read_en(rd_en), .i_addr_r(rd_addr),
        .o_data(dn), .o_act(an), .o_rd_valid(rvn)
    );

    typedef struct { int due; logic [7:0] q0; logic [1:0] a0; logic [7:0] qn; logic [1:0] an; } rd_exp_t;
    typedef struct { int due; bit i0; bit in; } imp_exp_t;

    rd_exp_t    rdq[$];
    imp_exp_t   impq[$];
    logic [9:0] m0 [64];
    logic [9:0] mn [64];
    int         cyc = 0, n_chk = 0, n_pass = 0, lat = 0;
    bit         ready_m = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic init_model();
        for (int i = 0; i < 64; i++) begin
            m0[i] = 10'h000;
            mn[i] = {8'h80, 2'b00};
        end
    endtask

    function automatic logic [9:0] upd_entry(input logic [9:0] e, input logic [7:0] d,
                                             input logic [1:0] a, output bit imp);
        imp = $signed(d) > $signed(e[9:2]);
        return imp ? {d, a} : e;
    endfunction

    // One clock: drive inputs, push expectations, take the edge, compare what is due.
    task automatic step(input bit r, input bit u, input logic [5:0] ua, input logic [7:0] ud,
                        input logic [1:0] uact, input bit re, input logic [5:0] ra, input bit c);
        bit       i0, i_n;
        rd_exp_t  er;
        imp_exp_t ei;
        rst = r; upd_v = u; upd_addr = ua; upd_data = ud; upd_act = uact;
        rd_en = re; rd_addr = ra; clr = c;
        if (r) begin
            rdq.delete();
            impq.delete();
            init_model();
            ready_m = 1'b0;
        end else if (ready_m) begin
            if (re) rdq.push_back('{cyc + 1, m0[ra][9:2], m0[ra][1:0], mn[ra][9:2], mn[ra][1:0]});
            if (c) begin
                init_model();
                ready_m = 1'b0;
            end else if (u) begin
                m0[ua] = upd_entry(m0[ua], ud, uact, i0);
                mn[ua] = upd_entry(mn[ua], ud, uact, i_n);
                impq.push_back('{cyc + 2, i0, i_n});
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        if (rdq.size() > 0 && rdq[0].due == cyc) begin
            er = rdq.pop_front();
            check("rd_valid0", rv0, 1);
            check("rd_validn", rvn, 1);
            check("rd_data0", d0, er.q0);
            check("rd_act0", a0, er.a0);
            check("rd_datan", dn, er.qn);
            check("rd_actn", an, er.an);
        end else begin
            check("rd_idle0", rv0, 0);
            check("rd_idlen", rvn, 0);
        end
        if (impq.size() > 0 && impq[0].due == cyc) begin
            ei = impq.pop_front();
            check("improved0", imp0, ei.i0);
            check("improvedn", impn, ei.in);
        end else begin
            check("imp_idle0", imp0, 0);
            check("imp_idlen", impn, 0);
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic upd(input logic [5:0] a, input logic [7:0] d, input logic [1:0] act);
        step(0, 1, a, d, act, 0, 0, 0);
    endtask

    task automatic rd(input logic [5:0] a);
        step(0, 0, 0, 0, 0, 1, a, 0);
    endtask

    // Steps until o_ready rises (bounded); junk drives requests that must be ignored.
    task automatic wait_ready(input bit junk, output int n);
        n = 0;
        while (ready0 !== 1'b1 && n < 200) begin
            if (junk) step(0, 1, 2, 8'd100, 1, 1, 2, 1);
            else idle();
            n++;
        end
        check("ready_latency", n, 64);
        check("ready_n", readyn, 1);
        ready_m = 1'b1;
    endtask

    initial begin
        init_model();
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        check("reset_ready", ready0, 0);
        check("reset_data", d0, 0);
        check("reset_act", a0, 0);
        wait_ready(0, lat);

        rd(0); rd(31); rd(63); idle(); idle();

        upd(5, 8'd20, 1); upd(5, 8'd10, 2); idle(); rd(5); idle(); idle();

        upd(7, 8'd3, 0); upd(7, 8'd9, 1); upd(7, 8'd6, 2); idle(); rd(7); idle(); idle();

        upd(3, 8'hFB, 0); idle(); rd(3); upd(3, 8'd0, 3); idle(); rd(3); idle(); idle();

        step(0, 1, 9, 8'd40, 2, 1, 9, 0);
        rd(9); idle(); idle();

        for (int i = 0; i < 80; i++)
            step(0, $urandom_range(0, 3) != 0, 6'($urandom_range(0, 7)), 8'($urandom),
                 2'($urandom), $urandom_range(0, 1) == 1, 6'($urandom_range(0, 7)), 0);
        for (int i = 0; i < 8; i++) rd(6'(i));
        idle(); idle();

        upd(12, 8'd55, 1); idle(); idle(); rd(12); idle();
        step(0, 1, 12, 8'd77, 3, 0, 0, 1);
        check("clear_ready_lo", ready0, 0);
        wait_ready(1, lat);
        rd(5); rd(7); rd(12); rd(9); idle(); idle();

        upd(11, 8'd50, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        wait_ready(0, lat);
        rd(11); idle(); idle();

        upd(13, 8'd66, 2); idle(); idle();
        step(0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) begin
            idle();
            check("sweep_busy", ready0, 0);
        end
        step(1, 0, 0, 0, 0, 0, 0, 0);
        wait_ready(0, lat);
        rd(13); rd(63); idle(); idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/qmax_update_table.md
# qmax_update_table

Parametrised successor to the Q-max store: holds, per state, the running maximum Q value and the action that produced it. It performs compare-and-store updates internally through a 2-stage read-modify-write pipeline, with forwarding so back-to-back updates to one state are exact. It also provides a sweep-clear engine in place of simulation-only initialisation. It sits between the Q-update datapath, which issues updates, and the action-selection and target logic, which issue reads.

## Interface
- DATA_WIDTH, 8, signed Q value width (two's complement)
- ADDR_WIDTH, 6, state index width
- DEPTH, 64, number of states (must be ≤ 2^ADDR_WIDTH)
- ACT_WIDTH, 2, stored action index width
- INIT_VAL, 0, value written to every entry by reset/clear (action written as 0)

Ports:
- i_clk  in  1  clock; single clock domain
- i_rst  in  1  reset; synchronous, active-high
- i_clear  in  1  start sweep clear (accepted only when o_ready=1)
- o_ready  out  1  1 = updates/reads/clear accepted; 0 while sweeping
- i_upd_valid  in  1  update request
- i_upd_addr  in  ADDR_WIDTH  state to update
- i_upd_data  in  DATA_WIDTH  candidate Q (signed)
- i_upd_act  in  ACT_WIDTH  action producing candidate
- o_upd_improved  out  1  pulse: an accepted update replaced the stored entry
- i_read_en  in  1  read request
- i_addr_r  in  ADDR_WIDTH  read address
- o_data  out  DATA_WIDTH  stored max Q
- o_act  out  ACT_WIDTH  stored argmax action
- o_rd_valid  out  1  o_data/o_act valid this cycle

## Operation
- Reset: at the i_rst edge, all control registers clear, any pending update is dropped, and a sweep starts. Reset values: o_ready=0, o_upd_improved=0, o_rd_valid=0, o_data=0, o_act=0.
- FSM states: SWEEP, RUN.
  - SWEEP writes {INIT_VAL, 0} to addresses 0..DEPTH-1, one address per cycle. After address DEPTH-1, the FSM enters RUN with o_ready=1.
  - RUN → SWEEP on i_clear && o_ready.
- i_clear, i_upd_valid and i_read_en are ignored while o_ready=0; nothing is queued. A clear during SWEEP does not restart the sweep.
- An update is accepted when i_upd_valid && o_ready. Stage 1 reads the entry. Stage 2 compares candidate > stored, signed and strict. If greater, stage 2 writes {candidate, act} and pulses o_upd_improved. On a tie or smaller candidate, the entry is unchanged.
- Forwarding: if stage 2 writes address A while a new update to A sits in stage 1, the new update compares against the stage-2 result, not the stale RAM word. Results must equal strictly sequential application of updates in acceptance order.
- Simultaneous update and clear: the clear wins, and the update is not accepted.
- If the update and i_read_en arrive in the same cycle, both are accepted. The RAM is 1R1W (the update read and the host read share the read port through the stage-1 mux). The implementation may use two RAM copies to provide separate read ports.

## Timing
- Update accepted at edge T: RAM read at T, compare and write at edge T+1, o_upd_improved high in the cycle after T+1.
- Read accepted at edge T: o_data, o_act and o_rd_valid are registered and present in the cycle after T, for 1 cycle.
- Read coherence: a read at T reflects every update accepted at or before T-1, including the write landing at T (bypassed). It does not reflect an update accepted at T.
- Clear accepted at T: o_ready=0 from the cycle after T. The stage-2 write due at T+1 is discarded. The sweep writes address k at edge T+1+k. o_ready=1 in the cycle after edge T+DEPTH.
- Reset mid-sweep restarts the sweep from address 0. Reset mid-update drops the update, with no write and no o_upd_improved.
- Addresses ≥ DEPTH: updates and reads are ignored. No write happens, and o_rd_valid still pulses with data 0.

## Structure
- Shared package qmax_pkg: default widths (DATA_WIDTH, ADDR_WIDTH, ACT_WIDTH), FSM state enum {SWEEP, RUN}, the packed entry type {q, act}, and the INIT_VAL default.
- Sub-module qmax_sdp_ram: 1R1W BRAM-inferable RAM with registered read and no reset on the array. The top instantiates two copies (update path and host-read path), written identically.

## Test plan
- Reset: DEPTH=64, INIT_VAL=0. Deassert i_rst → o_ready rises exactly 64 cycles later. Reads of addresses 0, 31 and 63 return 0, act 0.
- Basic update: upd(5, 20, act 1) → o_upd_improved=1. upd(5, 10, act 2) → no pulse. Read 5 → 20, act 1.
- Back-to-back hazard: upd(7, 3, act 0), upd(7, 9, act 1), upd(7, 6, act 2) on consecutive cycles → pulses 1, 1, 0. Read 7 → 9, act 1.
- Signed/tie: upd(3, -5) after reset → no change (0 > -5). upd(3, 0, act 3) → tie, no change, act stays 0. With INIT_VAL=-128, upd(3, -5) → stored -5.
- Read bypass: upd(9, 40) at T, read 9 at T+1 → 40. Read 9 issued at T (same edge) → 0.
- Clear mid-stream: entries written, i_clear asserted together with i_upd_valid → update dropped, o_ready=0 for 64 cycles, all entries 0 afterwards. i_rst asserted mid-sweep → sweep restarts, o_ready rises 64 cycles after deassertion.
